// File: rtl/bf_loop_core_pkg.sv
// Shared opcode bytes and controller state encoding for the looping Brainfuck core.
package bf_loop_core_pkg;

   localparam logic [7:0] OP_RIGHT    = 8'h3E;
   localparam logic [7:0] OP_LEFT     = 8'h3C;
   localparam logic [7:0] OP_INC      = 8'h2B;
   localparam logic [7:0] OP_DEC      = 8'h2D;
   localparam logic [7:0] OP_OUT      = 8'h2E;
   localparam logic [7:0] OP_IN       = 8'h2C;
   localparam logic [7:0] OP_LOOP     = 8'h5B;
   localparam logic [7:0] OP_END_LOOP = 8'h5D;
   localparam logic [7:0] OP_END      = 8'h00;

   typedef enum logic [3:0] {
      S_BOOT,
      S_FETCH,
      S_DECODE,
      S_DREAD,
      S_EXEC,
      S_OUT,
      S_IN,
      S_SFETCH,
      S_SSCAN,
      S_HALT
   } state_t;

endpackage

// File: rtl/bf_loop_stack.sv
// Return-address stack for '[' / ']' loops; top is combinational from the newest entry.
module bf_loop_stack #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CW-1:0]    count_reg;
   logic [WIDTH-1:0] entry_q [DEPTH];
   logic [AW-1:0]    top_idx;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CW'(DEPTH));
   assign top_idx = AW'(count_reg - CW'(1));
   assign top     = empty ? '0 : entry_q[top_idx];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (push && !full) begin
         count_reg <= count_reg + CW'(1);
      end else if (pop && !empty) begin
         count_reg <= count_reg - CW'(1);
      end
   end

   // Each slot only captures when it is the next free position.
   genvar gi;
   for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            entry_reg <= '0;
         end else if (push && !full && (count_reg == CW'(gi))) begin
            entry_reg <= d;
         end
      end
      assign entry_q[gi] = entry_reg;
   end

endmodule

// File: rtl/bf_loop_core.sv
// Multi-cycle Brainfuck core: IROM fetch, DRAM read-modify-write, loop stack,
// forward bracket scanner for skipped loops, and valid/ready byte I/O.
module bf_loop_core
   import bf_loop_core_pkg::*;
#(
   parameter int IA_WIDTH    = 12,
   parameter int DA_WIDTH    = 12,
   parameter int DD_WIDTH    = 8,
   parameter int STACK_DEPTH = 16
) (
   input  logic                clk,
   input  logic                reset,
   output logic                ice,
   output logic [IA_WIDTH-1:0] ia,
   input  logic [7:0]          id,
   output logic                drce,
   output logic [DA_WIDTH-1:0] dra,
   input  logic [DD_WIDTH-1:0] drd,
   output logic                dwce,
   output logic [DA_WIDTH-1:0] dwa,
   output logic [DD_WIDTH-1:0] dwq,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DD_WIDTH-1:0] out_data,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DD_WIDTH-1:0] in_data,
   output logic                halted,
   output logic                error
);

   state_t              state_reg, state_next;
   logic [IA_WIDTH-1:0] pc_reg, pc_next;
   logic [DA_WIDTH-1:0] dp_reg, dp_next;
   logic [IA_WIDTH-1:0] depth_reg, depth_next;
   logic [7:0]          op_reg, op_next;
   logic [DD_WIDTH-1:0] out_data_reg, out_data_next;
   logic                error_reg, error_next;

   logic [IA_WIDTH-1:0] pc_inc;
   logic                stk_push, stk_pop, stk_empty, stk_full;
   logic [IA_WIDTH-1:0] stk_top;

   assign pc_inc = pc_reg + IA_WIDTH'(1);

   bf_loop_stack #(
      .WIDTH (IA_WIDTH),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk   (clk),
      .reset (reset),
      .push  (stk_push),
      .pop   (stk_pop),
      .d     (pc_inc),
      .top   (stk_top),
      .empty (stk_empty),
      .full  (stk_full)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= S_BOOT;
         pc_reg       <= '0;
         dp_reg       <= '0;
         depth_reg    <= '0;
         op_reg       <= '0;
         out_data_reg <= '0;
         error_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         dp_reg       <= dp_next;
         depth_reg    <= depth_next;
         op_reg       <= op_next;
         out_data_reg <= out_data_next;
         error_reg    <= error_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      dp_next       = dp_reg;
      depth_next    = depth_reg;
      op_next       = op_reg;
      out_data_next = out_data_reg;
      error_next    = error_reg;
      ice           = 1'b0;
      ia            = '0;
      drce          = 1'b0;
      dra           = '0;
      dwce          = 1'b0;
      dwa           = '0;
      dwq           = '0;
      out_valid     = 1'b0;
      in_ready      = 1'b0;
      stk_push      = 1'b0;
      stk_pop       = 1'b0;

      case (state_reg)
         S_BOOT: state_next = S_FETCH;

         S_FETCH: begin
            ice        = 1'b1;
            ia         = pc_reg;
            state_next = S_DECODE;
         end

         S_DECODE: begin
            case (id)
               OP_RIGHT: begin
                  dp_next    = dp_reg + DA_WIDTH'(1);
                  pc_next    = pc_inc;
                  state_next = S_FETCH;
               end
               OP_LEFT: begin
                  dp_next    = dp_reg - DA_WIDTH'(1);
                  pc_next    = pc_inc;
                  state_next = S_FETCH;
               end
               OP_END: state_next = S_HALT;
               OP_INC, OP_DEC, OP_OUT, OP_LOOP, OP_END_LOOP: begin
                  op_next    = id;
                  state_next = S_DREAD;
               end
               OP_IN: state_next = S_IN;
               default: begin
                  pc_next    = pc_inc;
                  state_next = S_FETCH;
               end
            endcase
         end

         S_DREAD: begin
            drce       = 1'b1;
            dra        = dp_reg;
            state_next = S_EXEC;
         end

         S_EXEC: begin
            case (op_reg)
               OP_INC, OP_DEC: begin
                  dwce       = 1'b1;
                  dwa        = dp_reg;
                  dwq        = (op_reg == OP_INC) ? drd + DD_WIDTH'(1) : drd - DD_WIDTH'(1);
                  pc_next    = pc_inc;
                  state_next = S_FETCH;
               end
               OP_OUT: begin
                  out_data_next = drd;
                  state_next    = S_OUT;
               end
               OP_LOOP: begin
                  if (drd != '0) begin
                     if (stk_full) begin
                        error_next = 1'b1;
                        state_next = S_HALT;
                     end else begin
                        stk_push   = 1'b1;
                        pc_next    = pc_inc;
                        state_next = S_FETCH;
                     end
                  end else begin
                     // Zero cell: scan forward for the matching ']' without touching the stack.
                     depth_next = IA_WIDTH'(1);
                     pc_next    = pc_inc;
                     state_next = S_SFETCH;
                  end
               end
               OP_END_LOOP: begin
                  if (stk_empty) begin
                     error_next = 1'b1;
                     state_next = S_HALT;
                  end else if (drd != '0) begin
                     pc_next    = stk_top;
                     state_next = S_FETCH;
                  end else begin
                     stk_pop    = 1'b1;
                     pc_next    = pc_inc;
                     state_next = S_FETCH;
                  end
               end
               default: begin
                  pc_next    = pc_inc;
                  state_next = S_FETCH;
               end
            endcase
         end

         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               pc_next    = pc_inc;
               state_next = S_FETCH;
            end
         end

         S_IN: begin
            in_ready = 1'b1;
            if (in_valid) begin
               dwce       = 1'b1;
               dwa        = dp_reg;
               dwq        = in_data;
               pc_next    = pc_inc;
               state_next = S_FETCH;
            end
         end

         S_SFETCH: begin
            ice        = 1'b1;
            ia         = pc_reg;
            state_next = S_SSCAN;
         end

         S_SSCAN: begin
            pc_next    = pc_inc;
            state_next = S_SFETCH;
            case (id)
               OP_LOOP: depth_next = depth_reg + IA_WIDTH'(1);
               OP_END_LOOP: begin
                  if (depth_reg == IA_WIDTH'(1)) begin
                     state_next = S_FETCH;
                  end else begin
                     depth_next = depth_reg - IA_WIDTH'(1);
                  end
               end
               OP_END: begin
                  pc_next    = pc_reg;
                  error_next = 1'b1;
                  state_next = S_HALT;
               end
               default: ;
            endcase
         end

         S_HALT: ;

         default: state_next = S_BOOT;
      endcase
   end

   assign out_data = out_data_reg;
   assign halted   = (state_reg == S_HALT);
   assign error    = error_reg;

endmodule

// File: tb/tb_bf_loop_core.sv
// Directed bench for bf_loop_core: an interpreter-level model predicts DRAM writes,
// output bytes, error status and cycle counts; one process checks the DUT every cycle.
module tb_bf_loop_core;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ice;
   logic [11:0] ia;
   logic [7:0]  id = '0;
   logic        drce;
   logic [11:0] dra;
   logic [7:0]  drd = '0;
   logic        dwce;
   logic [11:0] dwa;
   logic [7:0]  dwq;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        halted;
   logic        error;

   always #5 clk = ~clk;

   bf_loop_core dut (
      .clk       (clk),
      .reset     (reset),
      .ice       (ice),
      .ia        (ia),
      .id        (id),
      .drce      (drce),
      .dra       (dra),
      .drd       (drd),
      .dwce      (dwce),
      .dwa       (dwa),
      .dwq       (dwq),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .halted    (halted),
      .error     (error)
   );

   logic [7:0] irom [4096];
   logic [7:0] dram [4096];
   logic [7:0] mm   [4096];
   logic       dram_clr = 1'b0;

   // Synchronous memories: data one cycle after the strobe, writes land at the edge.
   always @(posedge clk) begin
      if (ice) id <= irom[ia];
      if (drce) drd <= dram[dra];
      if (dram_clr) begin
         for (int i = 0; i < 4096; i++) dram[i] <= '0;
      end else if (dwce) begin
         dram[dwa] <= dwq;
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Model results
   logic [11:0] exp_wa[$];
   logic [7:0]  exp_wd[$];
   logic [7:0]  exp_out[$];
   bit          exp_err;
   bit          exp_io;
   int          exp_cycles;

   // Observations
   logic [7:0]  obs_out[$];
   int          obs_wr_cnt;
   int          ov_cnt, ir_cnt, last_ov, last_ir;
   bit          running = 1'b0;
   int          in_delay = 0, out_delay = 0;

   // Handshake partners: assert ready/valid after a programmable number of waiting cycles.
   initial begin
      int out_wait, in_wait;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_wait  = 0;
      in_wait   = 0;
      forever begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            out_ready = (out_wait >= out_delay);
            out_wait++;
         end else begin
            out_wait  = 0;
            out_ready = 1'b0;
         end
         if (in_ready) begin
            in_valid = (in_wait >= in_delay);
            in_wait++;
         end else begin
            in_wait  = 0;
            in_valid = 1'b0;
         end
      end
   end

   // Plain Brainfuck interpreter with a bounded loop stack.
   task automatic model(input logic [7:0] ib);
      logic [11:0] pc, dp, p;
      logic [11:0] stk[$];
      logic [7:0]  c;
      int          depth;
      bit          fin;
      for (int i = 0; i < 4096; i++) mm[i] = '0;
      exp_wa.delete();
      exp_wd.delete();
      exp_out.delete();
      exp_err = 0;
      exp_io = 0;
      exp_cycles = 1;
      pc = '0;
      dp = '0;
      fin = 0;
      for (int step = 0; step < 20000 && !fin; step++) begin
         c = irom[pc];
         case (c)
            8'h3E: begin dp = dp + 12'd1; pc = pc + 12'd1; exp_cycles += 2; end
            8'h3C: begin dp = dp - 12'd1; pc = pc + 12'd1; exp_cycles += 2; end
            8'h00: begin exp_cycles += 2; fin = 1; end
            8'h2B, 8'h2D: begin
               mm[dp] = (c == 8'h2B) ? mm[dp] + 8'd1 : mm[dp] - 8'd1;
               exp_wa.push_back(dp);
               exp_wd.push_back(mm[dp]);
               pc = pc + 12'd1;
               exp_cycles += 4;
            end
            8'h2E: begin exp_io = 1; exp_out.push_back(mm[dp]); pc = pc + 12'd1; end
            8'h2C: begin
               exp_io = 1;
               mm[dp] = ib;
               exp_wa.push_back(dp);
               exp_wd.push_back(ib);
               pc = pc + 12'd1;
            end
            8'h5B: begin
               exp_cycles += 4;
               if (mm[dp] != 0) begin
                  if (stk.size() >= 16) begin exp_err = 1; fin = 1; end
                  else begin stk.push_back(pc + 12'd1); pc = pc + 12'd1; end
               end else begin
                  depth = 1;
                  p = pc + 12'd1;
                  while (!fin && depth > 0) begin
                     c = irom[p];
                     exp_cycles += 2;
                     if (c == 8'h00) begin
                        exp_err = 1;
                        fin = 1;
                     end else begin
                        if (c == 8'h5B) depth++;
                        else if (c == 8'h5D) depth--;
                        p = p + 12'd1;
                     end
                  end
                  pc = p;
               end
            end
            8'h5D: begin
               exp_cycles += 4;
               if (stk.size() == 0) begin exp_err = 1; fin = 1; end
               else if (mm[dp] != 0) pc = stk[$];
               else begin void'(stk.pop_back()); pc = pc + 12'd1; end
            end
            default: begin pc = pc + 12'd1; exp_cycles += 2; end
         endcase
      end
   endtask

   // Per-cycle comparison against the model's transaction queues.
   always @(negedge clk) begin
      if (running && reset) begin
         if (dwce) begin
            obs_wr_cnt++;
            if (exp_wa.size() == 0) begin
               chk("wr_extra", {20'd0, dwa}, 32'hFFFF_FFFF);
            end else begin
               chk("wr_addr", {20'd0, dwa}, {20'd0, exp_wa.pop_front()});
               chk("wr_data", {24'd0, dwq}, {24'd0, exp_wd.pop_front()});
            end
         end
         if (out_valid) ov_cnt++;
         if (in_ready) ir_cnt++;
         if (out_valid && out_ready) begin
            $display("xfer out %02h", out_data);
            obs_out.push_back(out_data);
            if (exp_out.size() == 0) chk("out_extra", {24'd0, out_data}, 32'hFFFF_FFFF);
            else chk("out_data", {24'd0, out_data}, {24'd0, exp_out.pop_front()});
            last_ov = ov_cnt;
            ov_cnt = 0;
         end
         if (in_ready && in_valid) begin
            $display("xfer in %02h", in_data);
            last_ir = ir_cnt;
            ir_cnt = 0;
         end
         if (error) chk("err_with_halt", {31'd0, halted}, 32'd1);
      end
   end

   task automatic load_prog(input string s);
      for (int i = 0; i < 4096; i++) irom[i] = 8'h00;
      for (int i = 0; i < s.len(); i++) irom[i] = s[i];
   endtask

   task automatic run_test(input string name, input string prog, input logic [7:0] ib,
                           input int idly, input int odly);
      int cyc;
      bit done;
      reset = 1'b0;
      running = 1'b0;
      load_prog(prog);
      in_data = ib;
      in_delay = idly;
      out_delay = odly;
      model(ib);
      obs_out.delete();
      obs_wr_cnt = 0;
      ov_cnt = 0;
      ir_cnt = 0;
      last_ov = 0;
      last_ir = 0;
      dram_clr = 1'b1;
      @(posedge clk);
      #1 dram_clr = 1'b0;
      @(negedge clk);
      chk({name, "_rst_outs"}, {ice, drce, dwce, out_valid, in_ready, halted, error, 1'b0,
                               ia, out_data, 4'd0}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      running = 1'b1;
      chk({name, "_boot_ice"}, {31'd0, ice}, 32'd0);
      @(posedge clk);
      #1;
      chk({name, "_first_ice"}, {31'd0, ice}, 32'd1);
      chk({name, "_first_ia"}, {20'd0, ia}, 32'd0);
      cyc = 1;
      done = 0;
      while (!done && cyc < 5000) begin
         if (halted) done = 1;
         else begin
            @(posedge clk);
            #1;
            cyc++;
         end
      end
      @(negedge clk);
      running = 1'b0;
      chk({name, "_halted"}, {31'd0, halted}, 32'd1);
      chk({name, "_error"}, {31'd0, error}, {31'd0, exp_err});
      chk({name, "_writes_left"}, exp_wa.size(), 32'd0);
      chk({name, "_outs_left"}, exp_out.size(), 32'd0);
      if (!exp_io) chk({name, "_cycles"}, cyc, exp_cycles);
      $display("test %s: %0d cycles, %0d writes, %0d outputs", name, cyc, obs_wr_cnt, obs_out.size());
   endtask

   initial begin
      string s;

      run_test("inc_out", "+++.", 8'h00, 0, 0);
      chk("inc_out_nwr", obs_wr_cnt, 32'd3);
      chk("inc_out_nout", obs_out.size(), 32'd1);
      chk("inc_out_byte", {24'd0, obs_out[0]}, 32'h03);

      run_test("in_out", ",.", 8'h41, 5, 3);
      chk("in_out_cell", {24'd0, dram[0]}, 32'h41);
      chk("in_out_ready_cycles", last_ir, 32'd6);
      chk("in_out_valid_cycles", last_ov, 32'd4);
      chk("in_out_byte", {24'd0, obs_out[0]}, 32'h41);

      run_test("loop", "++[>+<-]>.", 8'h00, 0, 0);
      chk("loop_cell1", {24'd0, dram[1]}, 32'd2);
      chk("loop_cell0", {24'd0, dram[0]}, 32'd0);
      chk("loop_byte", {24'd0, obs_out[0]}, 32'd2);
      chk("loop_nwr", obs_wr_cnt, 32'd6);

      run_test("skip", "[[+]+].", 8'h00, 0, 0);
      chk("skip_nwr", obs_wr_cnt, 32'd0);
      chk("skip_nout", obs_out.size(), 32'd1);
      chk("skip_byte", {24'd0, obs_out[0]}, 32'd0);

      run_test("underflow", "+]", 8'h00, 0, 0);
      chk("underflow_model_err", {31'd0, exp_err}, 32'd1);
      chk("underflow_model_cyc", exp_cycles, 32'd9);

      s = "+";
      for (int i = 0; i < 17; i++) s = {s, "["};
      run_test("overflow", s, 8'h00, 0, 0);
      chk("overflow_model_cyc", exp_cycles, 32'd73);
      chk("overflow_err", {31'd0, error}, 32'd1);

      run_test("unmatched", "[", 8'h00, 0, 0);
      chk("unmatched_model_cyc", exp_cycles, 32'd7);
      chk("unmatched_err", {31'd0, error}, 32'd1);

      run_test("wrap", "<x-", 8'h00, 0, 0);
      chk("wrap_cell", {24'd0, dram[12'hFFF]}, 32'hFF);
      chk("wrap_model_cyc", exp_cycles, 32'd11);

      // Reset arriving while the core waits on the input channel.
      reset = 1'b0;
      running = 1'b0;
      load_prog(",");
      exp_wa.delete();
      exp_wd.delete();
      exp_out.delete();
      in_delay = 1000;
      in_data = 8'h5A;
      @(posedge clk);
      #1 reset = 1'b1;
      running = 1'b1;
      for (int k = 0; k < 20 && !in_ready; k++) begin
         @(posedge clk);
         #1;
      end
      chk("midin_waiting", {31'd0, in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      chk("midin_ready_drop", {31'd0, in_ready}, 32'd0);
      chk("midin_quiet", {ice, drce, dwce, halted, error}, 32'd0);
      running = 1'b0;
      run_test("restart", ",", 8'h5A, 0, 0);
      chk("restart_cell", {24'd0, dram[0]}, 32'h5A);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
